// File: rtl/counter_n_buttons.sv
// Up/down counter driven by three active-low push buttons.
// Each button is synchronised, debounced and edge-detected into one press event.
module counter_n_buttons #(
    parameter int WIDTH           = 4,
    parameter int STEP_N          = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [2:0]       Push,
    output logic [WIDTH-1:0] Cnt_o_LED,
    output logic [6:0]       Cnt_o_FND
);

    localparam int               DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_W  = WIDTH'(0);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP_N);

    logic [2:0]       sync1_r;
    logic [2:0]       sync2_r;
    logic [2:0]       press_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Hex digit to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    // Two-flop synchroniser; released (1) is the reset level so no press appears out of reset
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
        end else begin
            sync1_r <= Push;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic            level_r;
        logic            level_d_r;
        logic [DB_W-1:0] db_cnt_r;

        // Debounce: accept the new level after DEBOUNCE_CYCLES consecutive differing samples
        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                level_r  <= 1'b1;
                db_cnt_r <= '0;
            end else if (sync2_r[i] == level_r) begin
                db_cnt_r <= '0;
            end else if (db_cnt_r == DB_LAST) begin
                level_r  <= sync2_r[i];
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + DB_ONE;
            end
        end

        // Previous accepted level for falling-edge detection
        always_ff @(posedge Clk or negedge Rst) begin
            if (!Rst) begin
                level_d_r <= 1'b1;
            end else begin
                level_d_r <= level_r;
            end
        end

        assign press_s[i] = level_d_r & ~level_r;
    end

    // Simultaneous events are summed; the WIDTH-bit result wraps naturally
    always_comb begin
        count_next_s = count_r
                     + (press_s[0] ? ONE_W  : ZERO_W)
                     - (press_s[1] ? ONE_W  : ZERO_W)
                     + (press_s[2] ? STEP_W : ZERO_W);
    end

    // Count register
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count_r <= ZERO_W;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign Cnt_o_LED = count_r;
    assign Cnt_o_FND = hex_to_seg(count_r[3:0]);

endmodule

// File: tb/tb_counter_n_buttons.sv
// Self-checking bench for counter_n_buttons: directed table, corner sequences
// and random button activity against a sample-window reference model.
module tb_counter_n_buttons;

    localparam int DB   = 4;
    localparam int STEP = 3;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic       Clk;
    logic       Rst;
    logic [2:0] Push;
    logic [3:0] Cnt_o_LED;
    logic [6:0] Cnt_o_FND;

    int checks = 0;
    int errors = 0;

    counter_n_buttons #(.WIDTH(4), .STEP_N(STEP), .DEBOUNCE_CYCLES(DB)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Push      (Push),
        .Cnt_o_LED (Cnt_o_LED),
        .Cnt_o_FND (Cnt_o_FND)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: a button's accepted level flips once the last DB samples seen
    // after the 2-cycle synchroniser all disagree with it; a 1->0 flip is a press,
    // which moves the count on the following edge.
    logic [2:0] raw_q [$];
    logic [2:0] acc_m;
    logic [2:0] pulse_m;
    logic [3:0] count_m;
    int         sum_m;
    int         idx_m;
    logic       flip_m;
    logic       smp_m;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            raw_q.delete();
            acc_m   = 3'b111;
            pulse_m = 3'b000;
            count_m = 4'd0;
        end else begin
            sum_m = int'(count_m);
            if (pulse_m[0]) sum_m = sum_m + 1;
            if (pulse_m[1]) sum_m = sum_m - 1;
            if (pulse_m[2]) sum_m = sum_m + STEP;
            count_m = 4'(((sum_m % 16) + 16) % 16);
            raw_q.push_back(Push);
            if (raw_q.size() > 32) void'(raw_q.pop_front());
            pulse_m = 3'b000;
            for (int b = 0; b < 3; b++) begin
                flip_m = 1'b1;
                for (int k = 0; k < DB; k++) begin
                    idx_m = raw_q.size() - 3 - k;
                    smp_m = (idx_m >= 0) ? raw_q[idx_m][b] : 1'b1;
                    if (smp_m == acc_m[b]) flip_m = 1'b0;
                end
                if (flip_m) begin
                    pulse_m[b] = acc_m[b];
                    acc_m[b]   = ~acc_m[b];
                end
            end
        end
    end

    always @(negedge Clk) begin
        checks++;
        if (Cnt_o_LED !== count_m) begin
            errors++;
            $display("FAIL model_led @%0t: Cnt_o_LED=%0d expected %0d", $time, Cnt_o_LED, count_m);
        end
        checks++;
        if (Cnt_o_FND !== SEG_TAB[count_m]) begin
            errors++;
            $display("FAIL model_fnd @%0t: Cnt_o_FND=%b expected %b", $time, Cnt_o_FND, SEG_TAB[count_m]);
        end
    end

    task automatic chk_led(input string nm, input logic [3:0] exp);
        checks++;
        if (Cnt_o_LED !== exp) begin
            errors++;
            $display("FAIL %s: Cnt_o_LED=%0d expected %0d", nm, Cnt_o_LED, exp);
        end
    endtask

    task automatic chk_fnd(input string nm, input logic [6:0] exp);
        checks++;
        if (Cnt_o_FND !== exp) begin
            errors++;
            $display("FAIL %s: Cnt_o_FND=%b expected %b", nm, Cnt_o_FND, exp);
        end
    endtask

    task automatic press(input logic [2:0] p, input int hold, input int rel);
        Push = p;
        repeat (hold) @(negedge Clk);
        Push = 3'b111;
        repeat (rel) @(negedge Clk);
    endtask

    typedef struct {
        logic [2:0] push;
        logic [3:0] exp_led;
        logic [6:0] exp_fnd;
    } vec_t;

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{3'b110, 4'd1,  7'b1111001};
        vecs[1]  = '{3'b110, 4'd2,  7'b0100100};
        vecs[2]  = '{3'b011, 4'd5,  7'b0010010};
        vecs[3]  = '{3'b101, 4'd4,  7'b0011001};
        vecs[4]  = '{3'b101, 4'd3,  7'b0110000};
        vecs[5]  = '{3'b101, 4'd2,  7'b0100100};
        vecs[6]  = '{3'b100, 4'd2,  7'b0100100};
        vecs[7]  = '{3'b000, 4'd5,  7'b0010010};
        vecs[8]  = '{3'b101, 4'd4,  7'b0011001};
        vecs[9]  = '{3'b101, 4'd3,  7'b0110000};
        vecs[10] = '{3'b101, 4'd2,  7'b0100100};
        vecs[11] = '{3'b101, 4'd1,  7'b1111001};
        vecs[12] = '{3'b101, 4'd0,  7'b1000000};
        vecs[13] = '{3'b101, 4'd15, 7'b0001110};
        vecs[14] = '{3'b110, 4'd0,  7'b1000000};
        vecs[15] = '{3'b101, 4'd15, 7'b0001110};
        vecs[16] = '{3'b101, 4'd14, 7'b0000110};
        vecs[17] = '{3'b011, 4'd1,  7'b1111001};

        Rst  = 1'b0;
        Push = 3'b111;
        repeat (2) @(negedge Clk);
        chk_led("reset_led", 4'd0);
        chk_fnd("reset_fnd", 7'b1000000);
        Rst = 1'b1;
        repeat (50) @(negedge Clk);
        chk_led("idle_50", 4'd0);

        // Directed table: each row is one clean press and release
        for (int i = 0; i < 18; i++) begin
            press(vecs[i].push, 10, 10);
            chk_led($sformatf("vec%0d_led", i), vecs[i].exp_led);
            chk_fnd($sformatf("vec%0d_fnd", i), vecs[i].exp_fnd);
        end

        // Latency: 2 sync + DB debounce + 1 update edges
        Push = 3'b110;
        repeat (2 + DB) @(negedge Clk);
        chk_led("latency_before", 4'd1);
        @(negedge Clk);
        chk_led("latency_at", 4'd2);
        repeat (10) @(negedge Clk);
        chk_led("hold_single", 4'd2);
        Push = 3'b111;
        repeat (10) @(negedge Clk);

        // Bounce then settle low: exactly one step
        Push = 3'b110;
        @(negedge Clk);
        Push = 3'b111;
        @(negedge Clk);
        Push = 3'b110;
        repeat (12) @(negedge Clk);
        Push = 3'b111;
        repeat (10) @(negedge Clk);
        chk_led("bounce_one_step", 4'd3);

        // Glitch shorter than the debounce window
        press(3'b110, DB - 1, 15);
        chk_led("glitch_ignored", 4'd3);

        // Reset in the middle of a held press, button still held afterwards
        Push = 3'b110;
        repeat (4) @(negedge Clk);
        #2 Rst = 1'b0;
        #1 chk_led("async_reset", 4'd0);
        chk_fnd("async_reset_fnd", 7'b1000000);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        chk_led("no_spurious", 4'd0);
        repeat (10) @(negedge Clk);
        chk_led("held_after_reset", 4'd1);
        Push = 3'b111;
        repeat (10) @(negedge Clk);

        // Random button activity, including short bounces and overlaps
        for (int i = 0; i < 300; i++) begin
            Push = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 10)) @(negedge Clk);
        end
        Push = 3'b111;
        repeat (20) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
